temp_sample_ctrl: RTL and testbench

//  Sequencing controller for the 8-bit temperature sensor path. Periodically requests a

---
 rtl/temp_sample_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_temp_sample_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/temp_sample_ctrl.sv
// -----------------------------------------------------------------------------
// temp_sample_ctrl
//
// Sequencing controller for the 8-bit temperature sensor path. Periodically
// requests a reading, averages 2**AVG_LOG2 readings and publishes the averaged
// temperature. It drives an over-temperature alarm with hysteresis and flags a
// sensor that stops answering.
//
// Parameters
//   SAMPLE_PERIOD  idle cycles in WAIT between sample requests (>=1)
//   AVG_LOG2       log2 of the number of readings averaged (0..4)
//   TIMEOUT        max cycles in REQ awaiting sensor_valid (>=1)
//
// Ports
//   clk, rst       rising-edge clock, asynchronous active-high reset
//   enable         run request; low forces IDLE on the next edge
//   hi_thresh      alarm set threshold (avg >= hi sets)
//   lo_thresh      alarm clear threshold (avg < lo clears)
//   sample_req     registered level request to the sensor
//   sensor_valid   qualifies sensor_data
//   sensor_data    raw reading
//   avg_temp       last averaged temperature
//   avg_valid      one-cycle pulse, high while avg_temp is freshly updated
//   over_temp      hysteretic alarm
//   timeout_err    sticky sensor timeout flag, cleared by enable=0
//   state_dbg      current FSM state (IDLE=0 WAIT=1 REQ=2 ACC=3 EVAL=4)
//   min_temp       lowest avg_temp since reset   (TEMP_MINMAX_EN only)
//   max_temp       highest avg_temp since reset  (TEMP_MINMAX_EN only)
//
// Optional feature macro: TEMP_MINMAX_EN adds the min/max tracking ports.
//
// Sensor handshake: sample_req rises on entry to REQ and stays high until the
// edge where sensor_valid is seen high in REQ; that edge accepts sensor_data.
// sensor_valid outside REQ is ignored. If sensor_valid arrives in the same
// cycle the timeout would expire, the reading is accepted.
// -----------------------------------------------------------------------------
module temp_sample_ctrl #(
    parameter int SAMPLE_PERIOD = 100,
    parameter int AVG_LOG2      = 2,
    parameter int TIMEOUT       = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [7:0] hi_thresh,
    input  logic [7:0] lo_thresh,
    output logic       sample_req,
    input  logic       sensor_valid,
    input  logic [7:0] sensor_data,
    output logic [7:0] avg_temp,
    output logic       avg_valid,
    output logic       over_temp,
    output logic       timeout_err,
    output logic [2:0] state_dbg
`ifdef TEMP_MINMAX_EN
    ,
    output logic [7:0] min_temp,
    output logic [7:0] max_temp
`endif
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WAIT = 3'd1,
        S_REQ  = 3'd2,
        S_ACC  = 3'd3,
        S_EVAL = 3'd4
    } state_t;

    localparam int SUM_W  = 8 + AVG_LOG2;
    localparam int CNT_W  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int WAIT_W = $clog2(SAMPLE_PERIOD + 1);
    localparam int TO_W   = $clog2(TIMEOUT + 1);

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'((1 << AVG_LOG2) - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SAMPLE_PERIOD - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT - 1);

    state_t             state, state_n;
    logic [SUM_W-1:0]   sum;
    logic [CNT_W-1:0]   cnt;
    logic [WAIT_W-1:0]  wait_cnt;
    logic [TO_W-1:0]    req_cnt;

    logic               wait_done;
    logic               req_expire;
    logic               last_sample;
    logic [7:0]         new_avg;
    logic               alarm_n;

    assign state_dbg = state;

    // ---------------------------------------------------------------------
    // Next-state and datapath decode
    // ---------------------------------------------------------------------
    always_comb begin
        state_n     = state;
        wait_done   = (wait_cnt == WAIT_LAST);
        req_expire  = (req_cnt == TO_LAST);
        last_sample = (cnt == CNT_LAST);
        // Sum is SUM_W bits wide, so the shifted result always fits in 8 bits.
        new_avg     = 8'(sum >> AVG_LOG2);
        alarm_n     = over_temp;

        // Set wins over clear when lo_thresh > hi_thresh.
        if (new_avg >= hi_thresh) begin
            alarm_n = 1'b1;
        end else if (new_avg < lo_thresh) begin
            alarm_n = 1'b0;
        end

        case (state)
            S_IDLE: if (enable) state_n = S_WAIT;
            S_WAIT: if (wait_done) state_n = S_REQ;
            S_REQ: begin
                if (sensor_valid) begin
                    state_n = S_ACC;
                end else if (req_expire) begin
                    state_n = S_WAIT;
                end
            end
            S_ACC:  state_n = last_sample ? S_EVAL : S_WAIT;
            S_EVAL: state_n = S_WAIT;
            default: state_n = S_IDLE;
        endcase

        if (!enable) begin
            state_n = S_IDLE;
        end
    end

    // ---------------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // ---------------------------------------------------------------------
    // Counters, accumulator and registered outputs
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum         <= '0;
            cnt         <= '0;
            wait_cnt    <= '0;
            req_cnt     <= '0;
            sample_req  <= 1'b0;
            avg_temp    <= 8'd0;
            avg_valid   <= 1'b0;
            over_temp   <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            avg_valid  <= 1'b0;
            sample_req <= (state_n == S_REQ);
            wait_cnt   <= (state == S_WAIT && state_n == S_WAIT) ? wait_cnt + WAIT_W'(1) : '0;
            req_cnt    <= (state == S_REQ && state_n == S_REQ) ? req_cnt + TO_W'(1) : '0;

            if (!enable) begin
                sum         <= '0;
                cnt         <= '0;
                timeout_err <= 1'b0;
            end else begin
                case (state)
                    S_REQ: begin
                        if (sensor_valid) begin
                            sum <= sum + SUM_W'(sensor_data);
                        end else if (req_expire) begin
                            timeout_err <= 1'b1;
                            sum         <= '0;
                            cnt         <= '0;
                        end
                    end
                    S_ACC: begin
                        // The average is registered on the ACC->EVAL edge so that
                        // avg_temp is already new during the EVAL cycle, where
                        // avg_valid is high.
                        if (last_sample) begin
                            avg_temp  <= new_avg;
                            avg_valid <= 1'b1;
                            over_temp <= alarm_n;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    S_EVAL: begin
                        sum <= '0;
                        cnt <= '0;
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef TEMP_MINMAX_EN
    // Min/max follow every published average and ignore enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            min_temp <= 8'hFF;
            max_temp <= 8'h00;
        end else if (state == S_ACC && enable && last_sample) begin
            if (new_avg < min_temp) min_temp <= new_avg;
            if (new_avg > max_temp) max_temp <= new_avg;
        end
    end
`endif

endmodule

// File: tb/tb_temp_sample_ctrl.sv
// -----------------------------------------------------------------------------
// Bench for temp_sample_ctrl with SAMPLE_PERIOD=4, AVG_LOG2=2, TIMEOUT=8.
// Directed vectors push their hand-computed {over_temp, avg_temp} into exp_q;
// a negedge monitor pops and compares on every avg_valid pulse.
// -----------------------------------------------------------------------------
module tb_temp_sample_ctrl;

  localparam int SP = 4;
  localparam int AL = 2;
  localparam int TO = 8;

  // clock / reset
  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [7:0] hi_thresh;
  logic [7:0] lo_thresh;
  logic       sample_req;
  logic       sensor_valid;
  logic [7:0] sensor_data;
  logic [7:0] avg_temp;
  logic       avg_valid;
  logic       over_temp;
  logic       timeout_err;
  logic [2:0] state_dbg;
`ifdef TEMP_MINMAX_EN
  logic [7:0] min_temp;
  logic [7:0] max_temp;
`endif

  always #5 clk = ~clk;

  temp_sample_ctrl #(
    .SAMPLE_PERIOD(SP),
    .AVG_LOG2     (AL),
    .TIMEOUT      (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .hi_thresh   (hi_thresh),
    .lo_thresh   (lo_thresh),
    .sample_req  (sample_req),
    .sensor_valid(sensor_valid),
    .sensor_data (sensor_data),
    .avg_temp    (avg_temp),
    .avg_valid   (avg_valid),
    .over_temp   (over_temp),
    .timeout_err (timeout_err),
    .state_dbg   (state_dbg)
`ifdef TEMP_MINMAX_EN
    ,
    .min_temp    (min_temp),
    .max_temp    (max_temp)
`endif
  );

  // scoreboard state
  int total = 0;
  int bad   = 0;
  logic [8:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // monitor
  always @(negedge clk) begin
    if (rst === 1'b0 && avg_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL avg_unexpected: got avg=%0d ot=%0d expected no pulse", avg_temp, over_temp);
      end else begin
        check("avg_out {ot,avg}", 32'({over_temp, avg_temp}), 32'(exp_q.pop_front()));
      end
    end
  end

  // driver tasks
  task automatic wait_req();
    int n;
    n = 0;
    while (sample_req !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sample_req !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL req_wait: got sample_req=%b expected 1 within 200 cycles", sample_req);
    end
  endtask

  // Answer the next request dly cycles after it is first seen.
  task automatic answer(input logic [7:0] data, input int dly);
    wait_req();
    repeat (dly) @(negedge clk);
    sensor_valid = 1'b1;
    sensor_data  = data;
    @(negedge clk);
    sensor_valid = 1'b0;
    check("req_drop", 32'(sample_req), 32'd0);
    check("acc_state", 32'(state_dbg), 32'd3);
  endtask

  task automatic run_group(input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                           input logic [7:0] d3, input int last_dly,
                           input logic [7:0] exp_avg, input logic exp_ot);
    exp_q.push_back({exp_ot, exp_avg});
    answer(d0, 1);
    answer(d1, 1);
    answer(d2, 1);
    answer(d3, last_dly);
    check("lat_acc_valid", 32'(avg_valid), 32'd0);
    @(negedge clk);
    check("lat_eval_valid", 32'(avg_valid), 32'd1);
    check("eval_state", 32'(state_dbg), 32'd4);
  endtask

  // watchdog
  initial begin
    #300000;
    bad++;
    $display("FAIL watchdog: got no finish expected finish before 300000");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // stimulus
  initial begin
    rst          = 1'b1;
    enable       = 1'b1;
    sensor_valid = 1'b0;
    sensor_data  = 8'd0;
    hi_thresh    = 8'd70;
    lo_thresh    = 8'd60;
    repeat (2) @(negedge clk);

    check("rst_sample_req", 32'(sample_req), 32'd0);
    check("rst_avg_temp", 32'(avg_temp), 32'd0);
    check("rst_avg_valid", 32'(avg_valid), 32'd0);
    check("rst_over_temp", 32'(over_temp), 32'd0);
    check("rst_timeout", 32'(timeout_err), 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);
`ifdef TEMP_MINMAX_EN
    check("rst_min", 32'(min_temp), 32'hFF);
    check("rst_max", 32'(max_temp), 32'h00);
`endif
    rst = 1'b0;

    // basic average and alarm hysteresis (hi=70, lo=60)
    run_group(8'd20, 8'd40, 8'd60, 8'd80, 1, 8'd50, 1'b0);
    run_group(8'd80, 8'd80, 8'd80, 8'd80, 1, 8'd80, 1'b1);
    run_group(8'd60, 8'd70, 8'd64, 8'd66, 1, 8'd65, 1'b1);
    run_group(8'd50, 8'd50, 8'd50, 8'd50, 1, 8'd50, 1'b0);

    // timeout after two partial samples: partial sum must be discarded
    answer(8'd0, 1);
    answer(8'd0, 1);
    wait_req();
    repeat (TO - 1) @(negedge clk);
    check("to_req_held", 32'(sample_req), 32'd1);
    check("to_not_yet", 32'(timeout_err), 32'd0);
    @(negedge clk);
    check("to_err_set", 32'(timeout_err), 32'd1);
    check("to_req_drop", 32'(sample_req), 32'd0);
    check("to_state_wait", 32'(state_dbg), 32'd1);
    run_group(8'd100, 8'd100, 8'd100, 8'd100, 1, 8'd100, 1'b1);
    check("to_sticky", 32'(timeout_err), 32'd1);

    // enable dropped after two of four samples
    answer(8'd200, 1);
    answer(8'd200, 1);
    enable = 1'b0;
    @(negedge clk);
    check("dis_state_idle", 32'(state_dbg), 32'd0);
    check("dis_req", 32'(sample_req), 32'd0);
    check("dis_to_clear", 32'(timeout_err), 32'd0);
    check("dis_avg_hold", 32'(avg_temp), 32'd100);
    check("dis_ot_hold", 32'(over_temp), 32'd1);
    repeat (3) @(negedge clk);
    check("dis_still_idle", 32'(state_dbg), 32'd0);
    enable = 1'b1;
    run_group(8'd8, 8'd12, 8'd16, 8'd20, 1, 8'd14, 1'b0);

    // full scale: no overflow
    run_group(8'd255, 8'd255, 8'd255, 8'd255, 1, 8'd255, 1'b1);

    // stray valid in WAIT is ignored; average truncates (7>>2 = 1)
    @(negedge clk);
    check("stray_in_wait", 32'(state_dbg), 32'd1);
    sensor_valid = 1'b1;
    sensor_data  = 8'd250;
    @(negedge clk);
    sensor_valid = 1'b0;
    run_group(8'd1, 8'd2, 8'd2, 8'd2, 1, 8'd1, 1'b0);

    // lo > hi: set wins; last reading arrives in the timeout cycle
    hi_thresh = 8'd10;
    lo_thresh = 8'd200;
    run_group(8'd100, 8'd100, 8'd100, 8'd100, TO - 1, 8'd100, 1'b1);
    check("late_valid_no_to", 32'(timeout_err), 32'd0);

`ifdef TEMP_MINMAX_EN
    check("minmax_min_a", 32'(min_temp), 32'd1);
    check("minmax_max_a", 32'(max_temp), 32'd255);
`endif

    // asynchronous reset in the middle of REQ
    wait_req();
    #2;
    rst = 1'b1;
    #1;
    check("arst_req", 32'(sample_req), 32'd0);
    check("arst_avg_valid", 32'(avg_valid), 32'd0);
    check("arst_over_temp", 32'(over_temp), 32'd0);
    check("arst_timeout", 32'(timeout_err), 32'd0);
    check("arst_state", 32'(state_dbg), 32'd0);
    check("arst_avg_temp", 32'(avg_temp), 32'd0);
`ifdef TEMP_MINMAX_EN
    check("arst_min", 32'(min_temp), 32'hFF);
    check("arst_max", 32'(max_temp), 32'h00);
`endif
    @(negedge clk);
    hi_thresh = 8'd70;
    lo_thresh = 8'd60;
    rst = 1'b0;

`ifdef TEMP_MINMAX_EN
    run_group(8'd50, 8'd50, 8'd50, 8'd50, 1, 8'd50, 1'b0);
    run_group(8'd80, 8'd80, 8'd80, 8'd80, 1, 8'd80, 1'b1);
    run_group(8'd30, 8'd30, 8'd30, 8'd30, 1, 8'd30, 1'b0);
    check("minmax_min_b", 32'(min_temp), 32'd30);
    check("minmax_max_b", 32'(max_temp), 32'd80);
`else
    run_group(8'd44, 8'd45, 8'd46, 8'd47, 1, 8'd45, 1'b0);
`endif

    repeat (5) @(negedge clk);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
